// File: rtl/sopc_pkg.sv
// Shared types, LED bit positions and the baud-to-bit-period table for sopc_core.
package sopc_pkg;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  localparam int LED_PAR = 8;
  localparam int LED_FRM = 9;
  localparam int LED_OVF = 10;
  localparam int LED_CNT = 11;

  function automatic int unsigned round_div(input int unsigned num, input int unsigned den);
    return (num + den / 2) / den;
  endfunction

  // Each branch divides constants only, so the table folds to literals; codes 13..15 run at 115200.
  function automatic int unsigned baud_count(input int unsigned clk_hz, input logic [3:0] sel);
    int unsigned n;
    case (sel)
      4'd0:    n = round_div(clk_hz, 300);
      4'd1:    n = round_div(clk_hz, 600);
      4'd2:    n = round_div(clk_hz, 1200);
      4'd3:    n = round_div(clk_hz, 2400);
      4'd4:    n = round_div(clk_hz, 4800);
      4'd5:    n = round_div(clk_hz, 9600);
      4'd6:    n = round_div(clk_hz, 19200);
      4'd7:    n = round_div(clk_hz, 38400);
      4'd8:    n = round_div(clk_hz, 57600);
      4'd9:    n = round_div(clk_hz, 115200);
      4'd10:   n = round_div(clk_hz, 230400);
      4'd11:   n = round_div(clk_hz, 460800);
      4'd12:   n = round_div(clk_hz, 921600);
      default: n = round_div(clk_hz, 115200);
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sopc_uart_rx.sv
// UART receiver: two-flop synchronizer and mid-bit sampling FSM with parity/stop checks.
module sopc_uart_rx
  import sopc_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int          CNT_W  = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  input  logic [3:0] baudm,
  input  logic       bit8,
  input  logic       pen,
  input  logic       ohel,
  output logic [7:0] data,
  output logic       done,
  output logic       parity_err,
  output logic       frame_err
);

  rx_state_t        state, state_next;
  logic [1:0]       sync;
  logic             rx_s, rx_prev, fall;
  logic [CNT_W-1:0] cnt, n_lat, half;
  logic [2:0]       bit_idx;
  logic             bit8_lat, pen_lat, ohel_lat, par_bit;
  logic [7:0]       shreg;
  logic             bit_end, half_end, last_bit;

  assign rx_s     = sync[1];
  assign fall     = rx_prev & ~rx_s;
  assign half     = n_lat >> 1;
  assign bit_end  = (cnt == n_lat - CNT_W'(1));
  assign half_end = (cnt == half - CNT_W'(1));
  assign last_bit = (bit_idx == (bit8_lat ? 3'd7 : 3'd6));

  always_ff @(posedge clk) begin
    if (reset) begin
      sync    <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync    <= {sync[0], rxd};
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= RX_IDLE;
    else       state <= state_next;
  end

  // A start edge that is high again at half a bit period is discarded as a glitch.
  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      RX_IDLE:   if (fall) state_next = RX_START;
      RX_START:  if (half_end) state_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:   if (bit_end && last_bit) state_next = pen_lat ? RX_PARITY : RX_STOP;
      RX_PARITY: if (bit_end) state_next = RX_STOP;
      RX_STOP: begin
        if (bit_end) begin
          state_next = RX_IDLE;
          done       = 1'b1;
        end
      end
      default:   state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      n_lat    <= '0;
      bit_idx  <= '0;
      bit8_lat <= 1'b1;
      pen_lat  <= 1'b0;
      ohel_lat <= 1'b0;
      par_bit  <= 1'b0;
      shreg    <= '0;
    end else begin
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (fall) begin
            n_lat    <= CNT_W'(baud_count(CLK_HZ, baudm));
            bit8_lat <= bit8;
            pen_lat  <= pen;
            ohel_lat <= ohel;
            shreg    <= '0;
            bit_idx  <= '0;
          end
        end
        RX_START: cnt <= half_end ? '0 : cnt + CNT_W'(1);
        default: begin
          cnt <= bit_end ? '0 : cnt + CNT_W'(1);
          if (bit_end && state == RX_DATA) begin
            shreg[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 3'd1;
          end
          if (bit_end && state == RX_PARITY) par_bit <= rx_s;
        end
      endcase
    end
  end

  // Status outputs are only meaningful in the cycle done is high.
  assign data       = shreg;
  assign parity_err = pen_lat & (par_bit != (^shreg ^ ohel_lat));
  assign frame_err  = ~rx_s;

endmodule

// File: rtl/sopc_core.sv
// UART core top: receiver, LED status register and, with SOPC_LOOPBACK_ECHO_EN defined,
// the one-entry holding register and echo transmitter.
module sopc_core
  import sopc_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int          CNT_W  = 19
) (
  input  logic        clk100mhz,
  input  logic        reset,
  input  logic [3:0]  baudm,
  input  logic        bit8,
  input  logic        pen,
  input  logic        ohel,
  input  logic        uart_txd_in,
  output logic        uart_rxd_out,
  output logic [15:0] leds
);

  logic [7:0] rx_data;
  logic       rx_done, rx_par_err, rx_frm_err;
  logic [7:0] led_byte;
  logic       par_flag, frm_flag, ovf_flag;
  logic [4:0] frame_cnt;

  sopc_uart_rx #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W)) u_rx (
    .clk        (clk100mhz),
    .reset      (reset),
    .rxd        (uart_txd_in),
    .baudm      (baudm),
    .bit8       (bit8),
    .pen        (pen),
    .ohel       (ohel),
    .data       (rx_data),
    .done       (rx_done),
    .parity_err (rx_par_err),
    .frame_err  (rx_frm_err)
  );

  always_ff @(posedge clk100mhz) begin
    if (reset) begin
      led_byte  <= '0;
      par_flag  <= 1'b0;
      frm_flag  <= 1'b0;
      frame_cnt <= '0;
    end else if (rx_done) begin
      led_byte  <= rx_data;
      par_flag  <= par_flag | rx_par_err;
      frm_flag  <= frm_flag | rx_frm_err;
      frame_cnt <= frame_cnt + 5'd1;
    end
  end

`ifdef SOPC_LOOPBACK_ECHO_EN
  tx_state_t        tx_state, tx_state_next;
  logic             hold_full, wr, load;
  logic [7:0]       hold_data, load_data, tx_shift;
  logic [CNT_W-1:0] tx_cnt, tx_n;
  logic [2:0]       tx_idx;
  logic             tx_bit8, tx_pen, tx_par;
  logic             tx_bit_end, tx_last_bit;

  assign wr          = rx_done & ~rx_frm_err;
  assign tx_bit_end  = (tx_cnt == tx_n - CNT_W'(1));
  assign tx_last_bit = (tx_idx == (tx_bit8 ? 3'd7 : 3'd6));
  assign load_data   = bit8 ? hold_data : {1'b0, hold_data[6:0]};

  // A write that finds the holding register occupied is dropped and flagged.
  always_ff @(posedge clk100mhz) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_data <= '0;
      ovf_flag  <= 1'b0;
    end else begin
      if (load) hold_full <= 1'b0;
      if (wr) begin
        if (hold_full) begin
          ovf_flag <= 1'b1;
        end else begin
          hold_full <= 1'b1;
          hold_data <= rx_data;
        end
      end
    end
  end

  always_ff @(posedge clk100mhz) begin
    if (reset) tx_state <= TX_IDLE;
    else       tx_state <= tx_state_next;
  end

  // Loading straight out of the stop bit keeps back-to-back echoes gap-free.
  always_comb begin
    tx_state_next = tx_state;
    load          = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (hold_full) begin
          load          = 1'b1;
          tx_state_next = TX_START;
        end
      end
      TX_START:  if (tx_bit_end) tx_state_next = TX_DATA;
      TX_DATA:   if (tx_bit_end && tx_last_bit) tx_state_next = tx_pen ? TX_PARITY : TX_STOP;
      TX_PARITY: if (tx_bit_end) tx_state_next = TX_STOP;
      TX_STOP: begin
        if (tx_bit_end) begin
          if (hold_full) begin
            load          = 1'b1;
            tx_state_next = TX_START;
          end else begin
            tx_state_next = TX_IDLE;
          end
        end
      end
      default:   tx_state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk100mhz) begin
    if (reset) begin
      tx_cnt   <= '0;
      tx_n     <= '0;
      tx_idx   <= '0;
      tx_bit8  <= 1'b1;
      tx_pen   <= 1'b0;
      tx_par   <= 1'b0;
      tx_shift <= '0;
    end else if (load) begin
      tx_cnt   <= '0;
      tx_n     <= CNT_W'(baud_count(CLK_HZ, baudm));
      tx_idx   <= '0;
      tx_bit8  <= bit8;
      tx_pen   <= pen;
      tx_par   <= ^load_data ^ ohel;
      tx_shift <= load_data;
    end else if (tx_state != TX_IDLE) begin
      tx_cnt <= tx_bit_end ? '0 : tx_cnt + CNT_W'(1);
      if (tx_state == TX_DATA && tx_bit_end) tx_idx <= tx_idx + 3'd1;
    end
  end

  always_comb begin
    uart_rxd_out = 1'b1;
    case (tx_state)
      TX_START:  uart_rxd_out = 1'b0;
      TX_DATA:   uart_rxd_out = tx_shift[tx_idx];
      TX_PARITY: uart_rxd_out = tx_par;
      default:   uart_rxd_out = 1'b1;
    endcase
  end
`else
  assign ovf_flag     = 1'b0;
  assign uart_rxd_out = 1'b1;
`endif

  always_comb begin
    leds                = 16'h0000;
    leds[7:0]           = led_byte;
    leds[LED_PAR]       = par_flag;
    leds[LED_FRM]       = frm_flag;
    leds[LED_OVF]       = ovf_flag;
    leds[LED_CNT +: 5]  = frame_cnt;
  end

endmodule

// File: tb/tb_sopc_core.sv
// Directed bench for sopc_core; echo-line checks are compiled in when SOPC_LOOPBACK_ECHO_EN is defined.
module tb_sopc_core;

  logic        clk100mhz = 1'b0;
  logic        reset;
  logic [3:0]  baudm;
  logic        bit8, pen, ohel, uart_txd_in;
  logic        uart_rxd_out;
  logic [15:0] leds;

  int checks = 0;
  int fails = 0;
  int tx_low_seen = 0;
  int low_before;

  sopc_core dut (
    .clk100mhz    (clk100mhz),
    .reset        (reset),
    .baudm        (baudm),
    .bit8         (bit8),
    .pen          (pen),
    .ohel         (ohel),
    .uart_txd_in  (uart_txd_in),
    .uart_rxd_out (uart_rxd_out),
    .leds         (leds)
  );

  always #5 clk100mhz = ~clk100mhz;

  always @(negedge clk100mhz) if (!reset && uart_rxd_out !== 1'b1) tx_low_seen++;

  task automatic waitClocks(input int n);
    repeat (n) @(negedge clk100mhz);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%04h, expected 0x%04h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input int nbits, input bit with_par,
                               input bit par_val, input bit stop_val, input int n);
    uart_txd_in = 1'b0;
    waitClocks(n);
    for (int i = 0; i < nbits; i++) begin
      uart_txd_in = data[i];
      waitClocks(n);
    end
    if (with_par) begin
      uart_txd_in = par_val;
      waitClocks(n);
    end
    uart_txd_in = stop_val;
    waitClocks(n);
    uart_txd_in = 1'b1;
  endtask

`ifdef SOPC_LOOPBACK_ECHO_EN
  // Start-bit length is measured as a low run, so echoed bytes must have bit 0 set.
  task automatic captureTx(input int n, input int nbits, input bit with_par,
                           output logic [7:0] data, output logic par, output logic stop,
                           output int start_len);
    int waited = 0;
    data = '0; par = 1'b0; stop = 1'b0; start_len = 0;
    while (uart_rxd_out !== 1'b0 && waited < 16 * n) begin
      @(negedge clk100mhz);
      waited++;
    end
    if (uart_rxd_out !== 1'b0) return;
    while (uart_rxd_out === 1'b0 && start_len < 2 * n) begin
      start_len++;
      @(negedge clk100mhz);
    end
    waitClocks(n / 2);
    for (int i = 0; i < nbits; i++) begin
      data[i] = uart_rxd_out;
      waitClocks(n);
    end
    if (with_par) begin
      par = uart_rxd_out;
      waitClocks(n);
    end
    stop = uart_rxd_out;
  endtask
`endif

  task automatic sendEchoed(input string tag, input logic [7:0] data, input int nbits,
                            input bit with_par, input bit par_val, input bit exp_par, input int n);
`ifdef SOPC_LOOPBACK_ECHO_EN
    logic [7:0] cd;
    logic cp, cs;
    int cl;
    fork
      applyStimulus(data, nbits, with_par, par_val, 1'b1, n);
      captureTx(n, nbits, with_par, cd, cp, cs, cl);
    join
    checkOutput({tag, "_echo_start_len"}, 16'(cl), 16'(n));
    checkOutput({tag, "_echo_data"}, {8'h00, cd}, {8'h00, data});
    checkOutput({tag, "_echo_par_stop"}, {14'd0, cp, cs}, {14'd0, with_par ? exp_par : 1'b0, 1'b1});
`else
    applyStimulus(data, nbits, with_par, par_val, 1'b1, n);
`endif
  endtask

  initial begin
    reset = 1'b1; baudm = 4'd11; bit8 = 1'b1; pen = 1'b0; ohel = 1'b0; uart_txd_in = 1'b1;
    waitClocks(10);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      waitClocks(500);
      checkOutput("idle_leds", leds, 16'h0000);
      checkOutput("idle_line", {15'd0, uart_rxd_out}, 16'h0001);
    end

    $display("[TB] 8N1 0x55 at 217 clocks/bit");
    sendEchoed("f55", 8'h55, 8, 1'b0, 1'b0, 1'b0, 217);
    checkOutput("leds_55", leds, 16'h0855);

    $display("[TB] odd parity 0xA3, good then bad parity");
    pen = 1'b1; ohel = 1'b1;
    sendEchoed("a3_good", 8'hA3, 8, 1'b1, 1'b1, 1'b1, 217);
    checkOutput("leds_a3_good", leds, 16'h10A3);
    sendEchoed("a3_bad", 8'hA3, 8, 1'b1, 1'b0, 1'b1, 217);
    checkOutput("leds_a3_bad", leds, 16'h19A3);

    $display("[TB] framing error 0x41");
    pen = 1'b0; ohel = 1'b0;
    low_before = tx_low_seen;
    applyStimulus(8'h41, 8, 1'b0, 1'b0, 1'b0, 217);
    waitClocks(3 * 217);
    checkOutput("leds_41", leds, 16'h2341);
    checkOutput("no_echo_41", 16'(tx_low_seen - low_before), 16'd0);

    $display("[TB] 7-bit 0x7F");
    bit8 = 1'b0;
    sendEchoed("f7f", 8'h7F, 7, 1'b0, 1'b0, 1'b0, 217);
    checkOutput("leds_7f", leds, 16'h2B7F);

    $display("[TB] three back-to-back frames at 109 clocks/bit");
    bit8 = 1'b1;
    waitClocks(2500);
    baudm = 4'd12;
    applyStimulus(8'h11, 8, 1'b0, 1'b0, 1'b1, 109);
    applyStimulus(8'h22, 8, 1'b0, 1'b0, 1'b1, 109);
    applyStimulus(8'h33, 8, 1'b0, 1'b0, 1'b1, 109);
    checkOutput("burst_ovf", {15'd0, leds[10]}, 16'h0000);
    checkOutput("burst_leds", leds, 16'h4333);
    waitClocks(3000);

    $display("[TB] one-clock glitch on idle line");
    uart_txd_in = 1'b0;
    waitClocks(1);
    uart_txd_in = 1'b1;
    waitClocks(2 * 109);
    checkOutput("glitch_leds", leds, 16'h4333);
    sendEchoed("a5", 8'hA5, 8, 1'b0, 1'b0, 1'b0, 109);
    checkOutput("leds_a5", leds, 16'h4BA5);
    waitClocks(500);

    $display("[TB] reset in the middle of a frame");
    applyStimulus(8'hF0, 8, 1'b0, 1'b0, 1'b1, 109);
    checkOutput("leds_f0", leds, 16'h53F0);
    uart_txd_in = 1'b0;
    waitClocks(30);
    reset = 1'b1;
    waitClocks(1);
    checkOutput("reset_leds", leds, 16'h0000);
    checkOutput("reset_line", {15'd0, uart_rxd_out}, 16'h0001);
    reset = 1'b0;
    uart_txd_in = 1'b1;
    waitClocks(300);
    checkOutput("post_reset_leds", leds, 16'h0000);
    checkOutput("post_reset_line", {15'd0, uart_rxd_out}, 16'h0001);

`ifdef SOPC_LOOPBACK_ECHO_EN
    checkOutput("echo_activity", {15'd0, tx_low_seen > 0}, 16'h0001);
`else
    checkOutput("line_never_low", 16'(tx_low_seen), 16'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
